// File: rtl/cover_pkg.sv
// Shared constants and types for the auto-cover map collector.
//   CoverWidth  - width of the SoC auto-cover vector
//   WordWidth   - width of one dump beat
//   NumWords    - number of dump beats needed to cover the map
//   IdxWidth    - width of the beat index
//   CountWidth  - width of the covered-point counter
//   PopWidth    - width of a single-beat popcount
package cover_pkg;

  localparam int unsigned CoverWidth = 7552;
  localparam int unsigned WordWidth  = 64;
  localparam int unsigned NumWords   = (CoverWidth + WordWidth - 1) / WordWidth;
  localparam int unsigned IdxWidth   = $clog2(NumWords);
  localparam int unsigned CountWidth = $clog2(CoverWidth + 1);
  localparam int unsigned PopWidth   = $clog2(WordWidth + 1);
  // Map rounded up to a whole number of beats; the top beat is zero-padded.
  localparam int unsigned PadWidth   = NumWords * WordWidth;
  localparam int unsigned BaseWidth  = $clog2(PadWidth);

  typedef logic [CoverWidth-1:0] cover_t;
  typedef logic [WordWidth-1:0]  word_t;
  typedef logic [IdxWidth-1:0]   idx_t;
  typedef logic [CountWidth-1:0] count_t;
  typedef logic [PadWidth-1:0]   pad_map_t;

  typedef enum logic [0:0] {
    DUMP_IDLE,
    DUMP_SEND
  } dump_state_e;

  // Zero-extend the map so every beat index selects a full word.
  function automatic pad_map_t pad_map(cover_t map);
    pad_map_t padded;
    padded = '0;
    padded[CoverWidth-1:0] = map;
    return padded;
  endfunction

endpackage

// File: rtl/cover_map_collector_if.sv
// Signal bundle between the fuzz harness / SoC side and the cover map collector.
//   Sampling:  clear_i, sample_en_i, cover_i  ->  new_cov_o
//   Dump:      dump_req_i, dump_ready_i  ->  dump_busy_o, dump_valid_o, dump_idx_o,
//              dump_data_o, dump_last_o, dump_done_o
//   Status:    total_count_o
// The slave modport is the collector's view; master is the driving side.
interface cover_map_collector_if;
  import cover_pkg::*;

  logic   clear_i;
  logic   sample_en_i;
  cover_t cover_i;
  logic   new_cov_o;
  logic   dump_req_i;
  logic   dump_busy_o;
  logic   dump_valid_o;
  logic   dump_ready_i;
  idx_t   dump_idx_o;
  word_t  dump_data_o;
  logic   dump_last_o;
  logic   dump_done_o;
  count_t total_count_o;

  modport slave (
    input  clear_i,
    input  sample_en_i,
    input  cover_i,
    output new_cov_o,
    input  dump_req_i,
    output dump_busy_o,
    output dump_valid_o,
    input  dump_ready_i,
    output dump_idx_o,
    output dump_data_o,
    output dump_last_o,
    output dump_done_o,
    output total_count_o
  );

  modport master (
    output clear_i,
    output sample_en_i,
    output cover_i,
    input  new_cov_o,
    output dump_req_i,
    input  dump_busy_o,
    input  dump_valid_o,
    output dump_ready_i,
    input  dump_idx_o,
    input  dump_data_o,
    input  dump_last_o,
    input  dump_done_o,
    input  total_count_o
  );

endinterface

// File: rtl/cover_popcount.sv
// Combinational population count built as a balanced adder tree.
//   data_i  - Width-bit input word
//   count_o - number of set bits in data_i
module cover_popcount #(
  parameter int unsigned Width = 64
) (
  input  logic [Width-1:0]           data_i,
  output logic [$clog2(Width+1)-1:0] count_o
);

  localparam int unsigned OutWidth = $clog2(Width + 1);
  localparam int          Levels   = $clog2(Width);
  localparam int unsigned Padded   = 1 << Levels;

  // tree[l][i] holds the count of leaf span i at level l; unused slots stay zero.
  logic [OutWidth-1:0] tree [Levels+1][Padded];

  always_comb begin
    tree = '{default: '0};
    for (int i = 0; i < Width; i++) begin
      tree[0][i] = OutWidth'(data_i[i]);
    end
    for (int l = 1; l <= Levels; l++) begin
      for (int i = 0; i < (Padded >> l); i++) begin
        tree[l][i] = tree[l-1][2*i] + tree[l-1][2*i+1];
      end
    end
  end

  assign count_o = tree[Levels][0];

endmodule

// File: rtl/cover_map_collector.sv
// Sticky auto-cover bitmap with a word-by-word dump port.
//   clk_i, rst_ni  - clock and asynchronous active-low reset
//   bus (slave)    - sampling inputs, new-coverage flag, valid/ready dump stream
//                    and the covered-point total from the last completed dump
// The map keeps sampling while a dump runs; each beat shows the map as it was
// on the cycle that beat was loaded, so a dump is not an atomic snapshot.
module cover_map_collector
  import cover_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_ni,
  cover_map_collector_if.slave   bus
);

  cover_t      map_q, map_d;
  logic        new_cov_q, new_cov_d;
  dump_state_e state_q, state_d;
  idx_t        idx_q, idx_d;
  word_t       data_q, data_d;
  logic        valid_q, valid_d;
  logic        done_q, done_d;
  count_t      acc_q, acc_d;
  count_t      total_q, total_d;

  logic                 handshake;
  logic                 is_last;
  logic [PopWidth-1:0]  beat_pop;
  count_t               acc_sum;
  idx_t                 idx_sel;
  logic [BaseWidth-1:0] word_base;
  pad_map_t             map_pad;
  word_t                word_sel;

  // Sticky map and new-coverage detection; clear drops the same-cycle sample.
  always_comb begin
    map_d     = map_q;
    new_cov_d = 1'b0;
    if (bus.clear_i) begin
      map_d = '0;
    end else if (bus.sample_en_i) begin
      map_d     = map_q | bus.cover_i;
      new_cov_d = |(bus.cover_i & ~map_q);
    end
  end

  cover_popcount #(
    .Width (WordWidth)
  ) u_popcount (
    .data_i  (data_q),
    .count_o (beat_pop)
  );

  assign handshake = valid_q & bus.dump_ready_i;
  assign is_last   = (idx_q == idx_t'(NumWords - 1));
  assign acc_sum   = acc_q + count_t'(beat_pop);

  // Word to load next: word 0 when starting, otherwise the following beat.
  // Holding idx_q on the last beat keeps the select in range.
  always_comb begin
    idx_sel = '0;
    if (state_q == DUMP_SEND) begin
      idx_sel = is_last ? idx_q : idx_q + 1'b1;
    end
  end

  assign map_pad   = pad_map(map_q);
  assign word_base = BaseWidth'(idx_sel) * BaseWidth'(WordWidth);
  assign word_sel  = map_pad[word_base +: WordWidth];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    valid_d = valid_q;
    acc_d   = acc_q;
    total_d = total_q;
    done_d  = 1'b0;

    if (bus.clear_i) begin
      // Abort any dump in flight; the total is invalidated with the map.
      state_d = DUMP_IDLE;
      valid_d = 1'b0;
      acc_d   = '0;
      total_d = '0;
    end else begin
      unique case (state_q)
        DUMP_IDLE: begin
          if (bus.dump_req_i) begin
            state_d = DUMP_SEND;
            idx_d   = '0;
            data_d  = word_sel;
            valid_d = 1'b1;
            acc_d   = '0;
          end
        end
        DUMP_SEND: begin
          if (handshake) begin
            acc_d = acc_sum;
            if (is_last) begin
              state_d = DUMP_IDLE;
              valid_d = 1'b0;
              total_d = acc_sum;
              done_d  = 1'b1;
            end else begin
              idx_d  = idx_sel;
              data_d = word_sel;
            end
          end
        end
        default: begin
          state_d = DUMP_IDLE;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      map_q     <= '0;
      new_cov_q <= 1'b0;
      state_q   <= DUMP_IDLE;
      idx_q     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      acc_q     <= '0;
      total_q   <= '0;
    end else begin
      map_q     <= map_d;
      new_cov_q <= new_cov_d;
      state_q   <= state_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      acc_q     <= acc_d;
      total_q   <= total_d;
    end
  end

  assign bus.new_cov_o     = new_cov_q;
  assign bus.dump_busy_o   = (state_q == DUMP_SEND);
  assign bus.dump_valid_o  = valid_q;
  assign bus.dump_idx_o    = idx_q;
  assign bus.dump_data_o   = data_q;
  assign bus.dump_last_o   = is_last;
  assign bus.dump_done_o   = done_q;
  assign bus.total_count_o = total_q;

endmodule

// File: tb/tb_cover_map_collector.sv
module tb_cover_map_collector;
  import cover_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   tests_run = 0;
  int   tests_failed = 0;

  cover_map_collector_if bus ();

  cover_map_collector u_dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Reference model: the map as a plain bit set, the dump as "which beat is
  // on offer and what the map held when it was offered".
  bit [CoverWidth-1:0] m_map;
  bit                  m_newcov;
  bit                  m_busy;
  int                  m_idx;
  bit [WordWidth-1:0]  m_data;
  int                  m_acc;
  int                  m_total;
  bit                  m_done;

  bit [WordWidth-1:0]  beats [NumWords];
  int                  beat_pop_sum;

  function automatic bit [WordWidth-1:0] word_of(bit [CoverWidth-1:0] m, int k);
    bit [WordWidth-1:0] w = '0;
    for (int b = 0; b < int'(WordWidth); b++) begin
      if (k * int'(WordWidth) + b < int'(CoverWidth)) w[b] = m[k * int'(WordWidth) + b];
    end
    return w;
  endfunction

  function automatic cover_t rand_cover(int n);
    cover_t c = '0;
    for (int i = 0; i < n; i++) c[$urandom_range(CoverWidth - 1, 0)] = 1'b1;
    return c;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    assert (got === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_update();
    bit [CoverWidth-1:0] old = m_map;
    m_newcov = bus.sample_en_i && !bus.clear_i && ((bus.cover_i & ~old) != '0);
    m_done = 1'b0;
    if (bus.clear_i) begin
      m_busy = 1'b0; m_acc = 0; m_total = 0;
    end else if (!m_busy) begin
      if (bus.dump_req_i) begin
        m_busy = 1'b1; m_idx = 0; m_data = word_of(old, 0); m_acc = 0;
      end
    end else if (bus.dump_ready_i) begin
      m_acc += $countones(m_data);
      if (m_idx == int'(NumWords) - 1) begin
        m_busy = 1'b0; m_total = m_acc; m_done = 1'b1;
      end else begin
        m_idx++;
        m_data = word_of(old, m_idx);
      end
    end
    if (bus.clear_i) m_map = '0;
    else if (bus.sample_en_i) m_map = old | bus.cover_i;
  endtask

  // One clock: advance the model, let the DUT take the edge, compare.
  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    check("new_cov", bus.new_cov_o, m_newcov);
    check("dump_valid", bus.dump_valid_o, m_busy);
    check("dump_busy", bus.dump_busy_o, m_busy);
    check("dump_done", bus.dump_done_o, m_done);
    check("total_count", bus.total_count_o, m_total);
    if (m_busy) begin
      check("dump_idx", bus.dump_idx_o, m_idx);
      check("dump_data", bus.dump_data_o, m_data);
      check("dump_last", bus.dump_last_o, m_idx == int'(NumWords) - 1);
    end
  endtask

  // ready_mode: 0 always ready, 1 toggling, 2 random. abort_at >= 0 clears on that beat.
  task automatic run_dump(input int ready_mode, input bit busy_inputs, input int abort_at,
                          output int hs, output bit done_seen);
    bit aborting;
    hs = 0;
    done_seen = 1'b0;
    beat_pop_sum = 0;
    for (int k = 0; k < int'(NumWords); k++) beats[k] = '0;
    bus.dump_req_i = 1'b1;
    step();
    bus.dump_req_i = 1'b0;
    for (int cyc = 0; cyc < 400 && !done_seen; cyc++) begin
      case (ready_mode)
        0:       bus.dump_ready_i = 1'b1;
        1:       bus.dump_ready_i = (cyc % 2 == 0);
        default: bus.dump_ready_i = 1'($urandom_range(1, 0));
      endcase
      if (busy_inputs) begin
        bus.sample_en_i = 1'($urandom_range(1, 0));
        bus.cover_i     = rand_cover(int'($urandom_range(40, 1)));
        bus.dump_req_i  = ($urandom_range(7, 0) == 0);
      end
      aborting = (abort_at >= 0) && m_busy && (m_idx == abort_at);
      bus.clear_i = aborting;
      if (aborting) bus.dump_ready_i = 1'b0;
      if (bus.dump_valid_o && bus.dump_ready_i) begin
        hs++;
        beats[bus.dump_idx_o] = bus.dump_data_o;
        beat_pop_sum += $countones(bus.dump_data_o);
      end
      step();
      if (bus.dump_done_o) done_seen = 1'b1;
      if (aborting) break;
    end
    bus.clear_i      = 1'b0;
    bus.sample_en_i  = 1'b0;
    bus.dump_req_i   = 1'b0;
    bus.dump_ready_i = 1'b0;
    bus.cover_i      = '0;
    if (abort_at < 0) begin
      check("dump_done_seen", done_seen, 1'b1);
      check("dump_handshakes", hs, NumWords);
      check("total_vs_beats", bus.total_count_o, beat_pop_sum);
    end
  endtask

  task automatic sample(input cover_t c, input bit clr);
    bus.cover_i = c;
    bus.sample_en_i = 1'b1;
    bus.clear_i = clr;
    step();
    bus.sample_en_i = 1'b0;
    bus.clear_i = 1'b0;
    bus.cover_i = '0;
  endtask

  initial begin
    int     hs;
    bit     done_seen;
    cover_t c;
    word_t  acc_or;

    rst_n = 1'b0;
    bus.clear_i = 1'b0;
    bus.sample_en_i = 1'b0;
    bus.cover_i = '0;
    bus.dump_req_i = 1'b0;
    bus.dump_ready_i = 1'b0;
    m_map = '0; m_newcov = 0; m_busy = 0; m_idx = 0; m_data = '0;
    m_acc = 0; m_total = 0; m_done = 0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_new_cov", bus.new_cov_o, 1'b0);
    check("rst_busy", bus.dump_busy_o, 1'b0);
    check("rst_valid", bus.dump_valid_o, 1'b0);
    check("rst_idx", bus.dump_idx_o, 0);
    check("rst_data", bus.dump_data_o, 0);
    check("rst_last", bus.dump_last_o, 1'b0);
    check("rst_done", bus.dump_done_o, 1'b0);
    check("rst_total", bus.total_count_o, 0);
    rst_n = 1'b1;
    step();

    // Empty map dump, back-to-back beats
    run_dump(0, 1'b0, -1, hs, done_seen);
    acc_or = '0;
    for (int k = 0; k < int'(NumWords); k++) acc_or |= beats[k];
    check("empty_words", acc_or, 0);
    check("empty_total", bus.total_count_o, 0);

    // Lowest and highest cover points
    c = '0; c[0] = 1'b1;
    sample(c, 1'b0);
    check("new_cov_bit0", bus.new_cov_o, 1'b1);
    step();
    check("new_cov_idle", bus.new_cov_o, 1'b0);
    c = '0; c[CoverWidth-1] = 1'b1;
    sample(c, 1'b0);
    check("new_cov_top", bus.new_cov_o, 1'b1);
    step();
    run_dump(0, 1'b0, -1, hs, done_seen);
    check("word0_bit0", beats[0], 64'h1);
    check("word_last_top", beats[NumWords-1], 64'h8000_0000_0000_0000);
    check("total_two", bus.total_count_o, 2);

    // Repeated point is only new once
    c = '0; c[5] = 1'b1;
    sample(c, 1'b0);
    check("new_cov_bit5_first", bus.new_cov_o, 1'b1);
    sample(c, 1'b0);
    check("new_cov_bit5_again", bus.new_cov_o, 1'b0);
    run_dump(0, 1'b0, -1, hs, done_seen);
    check("word0_bits", beats[0], 64'h21);
    check("total_three", bus.total_count_o, 3);

    // Full map under back-pressure
    sample('1, 1'b0);
    check("new_cov_all", bus.new_cov_o, 1'b1);
    run_dump(1, 1'b0, -1, hs, done_seen);
    check("full_handshakes", hs, 118);
    check("full_total", bus.total_count_o, 7552);

    // Clear aborts a dump mid-stream
    run_dump(0, 1'b0, 40, hs, done_seen);
    check("abort_valid", bus.dump_valid_o, 1'b0);
    check("abort_busy", bus.dump_busy_o, 1'b0);
    check("abort_done", done_seen, 1'b0);
    check("abort_total", bus.total_count_o, 0);
    repeat (3) step();
    run_dump(0, 1'b0, -1, hs, done_seen);
    acc_or = '0;
    for (int k = 0; k < int'(NumWords); k++) acc_or |= beats[k];
    check("after_abort_words", acc_or, 0);
    check("after_abort_total", bus.total_count_o, 0);

    // Clear beats a same-cycle sample and a same-cycle request
    c = '0; c[3] = 1'b1;
    sample(c, 1'b0);
    sample('1, 1'b1);
    check("clear_sample_newcov", bus.new_cov_o, 1'b0);
    bus.dump_req_i = 1'b1;
    bus.clear_i = 1'b1;
    step();
    bus.dump_req_i = 1'b0;
    bus.clear_i = 1'b0;
    check("clear_req_busy", bus.dump_busy_o, 1'b0);
    check("clear_req_valid", bus.dump_valid_o, 1'b0);
    run_dump(0, 1'b0, -1, hs, done_seen);
    check("clear_sample_total", bus.total_count_o, 0);

    // Randomised sampling, back-pressure and ignored requests during dumps
    for (int r = 0; r < 6; r++) begin
      int idle_cycles = int'($urandom_range(20, 3));
      for (int i = 0; i < idle_cycles; i++) begin
        bus.sample_en_i = 1'($urandom_range(1, 0));
        bus.cover_i = rand_cover(int'($urandom_range(60, 1)));
        step();
      end
      bus.sample_en_i = 1'b0;
      run_dump(2, 1'b1, -1, hs, done_seen);
      check("rand_total", bus.total_count_o, m_total);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/cover_map_collector.md
Name: cover_map_collector

Overview:
- Sits directly downstream of the tiny-SoC toplevel and consumes its auto-cover vector each cycle.
- Accumulates the coverage bits into a sticky bitmap.
- On request, streams the bitmap out word by word over a valid/ready interface.
- Reports the total number of covered points and flags cycles that hit new coverage. The fuzz harness reads these between test cases.

Parameters:
- CoverWidth, 7552, width of the incoming cover vector.
- WordWidth, 64, width of one dump beat.
- NumWords, ceil(CoverWidth/WordWidth) = 118, number of dump beats (derived, localparam).
- IdxWidth, $clog2(NumWords) = 7, dump index width (derived).
- CountWidth, $clog2(CoverWidth+1) = 13, covered-point counter width (derived).

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  asynchronous active-low reset.
- clear_i  input  1  synchronous clear of map/count; driven from the meta reset.
- sample_en_i  input  1  accumulate cover_i this cycle.
- cover_i  input  CoverWidth  auto-cover vector from the SoC.
- new_cov_o  output  1  registered pulse: previous sampled cycle set ≥1 new bit.
- dump_req_i  input  1  start a dump; sampled in IDLE only.
- dump_busy_o  output  1  high while state is SEND.
- dump_valid_o  output  1  dump beat valid.
- dump_ready_i  input  1  consumer ready.
- dump_idx_o  output  IdxWidth  word index of the current beat.
- dump_data_o  output  WordWidth  bitmap word; word k = map[k*WordWidth +: WordWidth], zero-padded above CoverWidth.
- dump_last_o  output  1  current beat is word NumWords-1.
- dump_done_o  output  1  one-cycle pulse after the final beat handshake.
- total_count_o  output  CountWidth  popcount of the map from the last completed dump.

Behaviour:
- Reset (rst_ni low, async): map=0, state=IDLE, all outputs 0, accumulator 0.
- Sticky map, per cycle:
  - If clear_i: map <= 0.
  - Else if sample_en_i: map <= map | cover_i.
  - clear_i wins over sample_en_i; that cycle's cover is dropped.
- new_cov_o: registered; next cycle = sample_en_i & ~clear_i & |(cover_i & ~map).
- FSM has two states, IDLE and SEND.
- IDLE:
  - If dump_req_i & ~clear_i: idx<=0, data reg <= word 0 of current map (pre-update value), valid<=1, acc<=0, go SEND.
  - First beat is valid 1 cycle after the request.
- SEND:
  - Handshake = valid & ready. Without a handshake, data, idx and last hold stable.
  - On handshake: acc <= acc + popcount(dump_data_o).
  - If last: valid<=0, go IDLE, total_count_o <= acc + popcount(dump_data_o), dump_done_o pulses next cycle.
  - Else: idx++, data reg <= word idx+1 of the map at that cycle, valid stays 1. Throughput is 1 beat/cycle with no bubbles.
- Sampling continues during a dump. Each word reflects the map at the cycle it is loaded into the output register. There is no global snapshot.
- dump_req_i in SEND is ignored (no queuing).
- clear_i in SEND aborts the dump:
  - Next cycle: valid=0, state IDLE, acc=0, total_count_o=0, no dump_done_o.
  - This is the only case where valid drops without a handshake; consumers must tolerate it.
- dump_req_i with clear_i in the same cycle: clear wins, no dump starts.
- total_count_o changes only on dump completion, clear_i, or reset.
- Index wrap: idx never exceeds NumWords-1; dump_last_o = (idx == NumWords-1).
- popcount is combinational on the 64-bit output register. Its sum is added to a CountWidth accumulator; overflow is impossible by construction.

Decomposition:
- Package cover_pkg:
  - CoverWidth, WordWidth, NumWords, IdxWidth, CountWidth constants.
  - typedefs cover_t, word_t, idx_t, count_t.
  - enum dump_state_e {DUMP_IDLE, DUMP_SEND}.
- Sub-module cover_popcount: parameterised width (WordWidth), purely combinational adder tree. Output is $clog2(WordWidth+1) bits.

Test Plan:
- Reset then dump with ready=1 -> 118 beats idx 0..117 back-to-back, all data 0, last on beat 117, done pulse, total_count_o=0.
- Sample cover_i bit 0 then bit 7551, dump -> word0=0x1, word117=0x8000_0000_0000_0000, total_count_o=2; new_cov_o pulses once after each sample.
- Same bit 5 sampled twice -> new_cov_o pulses only after the first sample; map bit 5 =1.
- Set all bits, dump with ready toggling 1/0 each cycle -> data and idx stable while ready=0, exactly 118 handshakes, total_count_o=7552.
- clear_i during beat 40 -> valid low next cycle, no done pulse, total_count_o=0; subsequent dump returns all zeros.
- clear_i and sample_en_i with cover_i=all-ones in same cycle -> map stays 0, new_cov_o=0; dump_req_i with clear_i -> no dump starts, dump_busy_o=0.
